// File: rtl/uart_cmd_responder_if.sv
// Serial-side bundle of the UART command responder.
// slave is the responder's view; master drives rx and watches the rest.
interface uart_cmd_responder_if #(
  parameter int IW = 1
);
  logic          rx;
  logic          tx;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          frame_err;
  logic          cmd_hit;
  logic [IW-1:0] cmd_idx;
  logic          cmd_drop;
  logic          busy;

  modport slave (
    input  rx,
    output tx, rx_valid, rx_byte, frame_err,
    output cmd_hit, cmd_idx, cmd_drop, busy
  );

  modport master (
    output rx,
    input  tx, rx_valid, rx_byte, frame_err,
    input  cmd_hit, cmd_idx, cmd_drop, busy
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART RX/TX pair with a table-driven command responder.
// A matched command byte triggers a fixed multi-byte reply.
module uart_cmd_responder #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int NUM_CMDS  = 2,
  parameter int RESP_LEN  = 4,
  parameter logic [NUM_CMDS*8-1:0] CMD_CODES = 16'h3231,
  parameter logic [NUM_CMDS*RESP_LEN*8-1:0] RESP_DATA =
    64'h43414C50_554E4343
) (
  input logic clk,
  input logic rst,
  uart_cmd_responder_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int IW  = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int JW  = (RESP_LEN > 1) ? $clog2(RESP_LEN) : 1;
  localparam int NR  = NUM_CMDS * RESP_LEN;
  localparam int FLW = (NR > 1) ? $clog2(NR) : 1;
  localparam int PB  = (PARITY != 0) ? 1 : 0;
  localparam int FW  = 9 + PB + STOP_BITS;
  localparam int BW  = $clog2(FW + 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_SEND, R_WAIT
  } r_st_t;

  logic          rx_s1_q;
  logic          rxs_q;
  logic [1:0]    fill_q;
  logic          armed_q;
  rx_st_t        rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_par_q;
  logic          rx_valid_q;
  logic [7:0]    rx_byte_q;
  logic          frame_err_q;
  logic          par_ok;

  r_st_t         r_st_q;
  logic [IW-1:0] idx_q;
  logic [JW-1:0] j_q;
  logic          tx_q;
  logic [FW-1:0] tx_sh_q;
  logic [CW-1:0] tx_cnt_q;
  logic [BW-1:0] tx_bits_q;
  logic          cmd_hit_q;
  logic          cmd_drop_q;
  logic          busy_q;

  logic          m_hit;
  logic [IW-1:0] m_idx;
  logic [JW-1:0] j_sel;
  logic [FLW-1:0] flat;
  logic [7:0]    resp_mem [NR];
  logic [7:0]    tx_byte;
  logic [FW-1:0] frame;

  // fill_q marks when rxs holds real line samples, not reset ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rxs_q   <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      rx_s1_q <= bus.rx;
      rxs_q   <= rx_s1_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && rxs_q) armed_q <= 1'b1;
    end
  end

  assign par_ok = (PB == 0) ? 1'b1 :
    (rx_par_q == ((^rx_sh_q) ^ (PARITY == 2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q     <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_par_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (rx_st_q)
        RX_IDLE: begin
          if (armed_q && !rxs_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= CW'(DIV / 2 - 1);
          end
        end
        RX_START: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else if (rxs_q) begin
            rx_st_q <= RX_IDLE;
          end else begin
            rx_st_q  <= RX_DATA;
            rx_cnt_q <= CW'(DIV - 1);
            rx_bit_q <= '0;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_sh_q  <= {rxs_q, rx_sh_q[7:1]};
            rx_cnt_q <= CW'(DIV - 1);
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7)
              rx_st_q <= (PB != 0) ? RX_PAR : RX_STOP;
          end
        end
        RX_PAR: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_par_q <= rxs_q;
            rx_cnt_q <= CW'(DIV - 1);
            rx_st_q  <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_st_q <= RX_IDLE;
            if (rxs_q && par_ok) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= rx_sh_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // descending scan so the lowest matching index wins
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (CMD_CODES[i*8 +: 8] == rx_byte_q) begin
        m_hit = 1'b1;
        m_idx = IW'(i);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NR; k++) resp_mem[k] = RESP_DATA[k*8 +: 8];
  end

  always_comb begin
    j_sel = j_q;
    if (r_st_q == R_WAIT && j_q != JW'(RESP_LEN - 1))
      j_sel = j_q + 1'b1;
    flat    = FLW'(int'(idx_q) * RESP_LEN + int'(j_sel));
    tx_byte = resp_mem[flat];
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = tx_byte;
    if (PB != 0) frame[9] = (^tx_byte) ^ (PARITY == 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_q     <= R_IDLE;
      idx_q      <= '0;
      j_q        <= '0;
      tx_q       <= 1'b1;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      cmd_hit_q  <= 1'b0;
      cmd_drop_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cmd_hit_q  <= 1'b0;
      cmd_drop_q <= rx_valid_q && (r_st_q != R_IDLE);
      unique case (r_st_q)
        R_IDLE: begin
          if (rx_valid_q && m_hit) begin
            cmd_hit_q <= 1'b1;
            idx_q     <= m_idx;
            j_q       <= '0;
            busy_q    <= 1'b1;
            r_st_q    <= R_SEND;
          end
        end
        R_SEND: begin
          tx_q      <= frame[0];
          tx_sh_q   <= {1'b1, frame[FW-1:1]};
          tx_bits_q <= BW'(FW - 1);
          tx_cnt_q  <= CW'(DIV - 1);
          r_st_q    <= R_WAIT;
        end
        R_WAIT: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end else if (tx_bits_q != '0) begin
            tx_q      <= tx_sh_q[0];
            tx_sh_q   <= {1'b1, tx_sh_q[FW-1:1]};
            tx_bits_q <= tx_bits_q - 1'b1;
            tx_cnt_q  <= CW'(DIV - 1);
          end else if (j_q == JW'(RESP_LEN - 1)) begin
            r_st_q <= R_IDLE;
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
          end else begin
            // next byte starts right after the stop period: gapless
            j_q       <= j_sel;
            tx_q      <= frame[0];
            tx_sh_q   <= {1'b1, frame[FW-1:1]};
            tx_bits_q <= BW'(FW - 1);
            tx_cnt_q  <= CW'(DIV - 1);
          end
        end
        default: r_st_q <= R_IDLE;
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_byte   = rx_byte_q;
  assign bus.frame_err = frame_err_q;
  assign bus.cmd_hit   = cmd_hit_q;
  assign bus.cmd_idx   = idx_q;
  assign bus.cmd_drop  = cmd_drop_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: two configurations, table vectors,
// hand sequences and random bytes checked against a string-table model.
module tb_uart_cmd_responder;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_responder_if #(.IW(1)) b0 ();
  uart_cmd_responder_if #(.IW(2)) b1 ();

  uart_cmd_responder #(
    .CLK_HZ(1000000), .BAUD(100000)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  uart_cmd_responder #(
    .CLK_HZ(1000000), .BAUD(100000),
    .PARITY(1), .STOP_BITS(2),
    .NUM_CMDS(3), .RESP_LEN(2),
    .CMD_CODES(24'h414140),
    .RESP_DATA(48'h666564636261)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  // reference tables, written as plain codes and strings
  logic [7:0] c0 [2] = '{8'h31, 8'h32};
  logic [7:0] c1 [3] = '{8'h40, 8'h41, 8'h41};
  string r0 [2] = '{"CCNU", "PLAC"};
  string r1 [3] = '{"ab", "cd", "ef"};

  function automatic int n_cmds(int w);
    return (w == 1) ? 3 : 2;
  endfunction
  function automatic int r_len(int w);
    return (w == 1) ? 2 : 4;
  endfunction
  function automatic int fw(int w);
    return (w == 1) ? 12 : 10;
  endfunction
  function automatic logic [7:0] code(int w, int i);
    return (w == 1) ? c1[i] : c0[i];
  endfunction
  function automatic int model_idx(int w, logic [7:0] b);
    for (int i = 0; i < n_cmds(w); i++)
      if (code(w, i) == b) return i;
    return -1;
  endfunction
  function automatic int model_byte(int w, int i, int j);
    string s;
    s = (w == 1) ? r1[i] : r0[i];
    return int'(s[j]);
  endfunction

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int nv[2], nf[2], nh[2], nd[2];
  int vcyc[2], hcyc[2], hidx[2], bfall[2];
  int vb[2];
  logic bprev[2];
  logic mact[2];
  int mt0[2], mbit[2];
  logic [11:0] mfr[2];
  int fbad[2];
  int txb[2][512];
  int txs[2][512];
  int ntx[2];

  logic t, v, f, h, d, bs, ok;
  logic [7:0] rb;
  int ix;

  // line monitor: counts pulses and decodes tx frames mid-bit
  initial begin
    for (int w = 0; w < 2; w++) begin
      nv[w] = 0; nf[w] = 0; nh[w] = 0; nd[w] = 0;
      vcyc[w] = 0; hcyc[w] = 0; hidx[w] = 0;
      bfall[w] = 0; vb[w] = 0; bprev[w] = 0;
      mact[w] = 0; mt0[w] = 0; mbit[w] = 0;
      mfr[w] = '0; fbad[w] = 0; ntx[w] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int w = 0; w < 2; w++) begin
        t  = (w == 1) ? b1.tx : b0.tx;
        v  = (w == 1) ? b1.rx_valid : b0.rx_valid;
        f  = (w == 1) ? b1.frame_err : b0.frame_err;
        h  = (w == 1) ? b1.cmd_hit : b0.cmd_hit;
        d  = (w == 1) ? b1.cmd_drop : b0.cmd_drop;
        bs = (w == 1) ? b1.busy : b0.busy;
        rb = (w == 1) ? b1.rx_byte : b0.rx_byte;
        ix = (w == 1) ? int'(b1.cmd_idx) : int'(b0.cmd_idx);
        if (rst) begin
          mact[w] = 0;
          bprev[w] = 0;
        end else begin
          if (v) begin nv[w]++; vcyc[w] = cyc; vb[w] = int'(rb); end
          if (f) nf[w]++;
          if (h) begin nh[w]++; hcyc[w] = cyc; hidx[w] = ix; end
          if (d) nd[w]++;
          if (bprev[w] && !bs) bfall[w] = cyc;
          bprev[w] = bs;
          if (!mact[w] && !t) begin
            mact[w] = 1; mt0[w] = cyc; mbit[w] = 0;
          end
          if (mact[w] && ((cyc - mt0[w]) % DIV == DIV / 2)) begin
            mfr[w][mbit[w]] = t;
            mbit[w]++;
            if (mbit[w] == fw(w)) begin
              mact[w] = 0;
              ok = (mfr[w][0] == 1'b0);
              if (w == 1) ok = ok && (mfr[w][9] == ^mfr[w][8:1]);
              for (int k = (w == 1) ? 10 : 9; k < fw(w); k++)
                ok = ok && mfr[w][k];
              if (!ok) fbad[w]++;
              if (ntx[w] < 512) begin
                txb[w][ntx[w]] = int'(mfr[w][8:1]);
                txs[w][ntx[w]] = mt0[w];
                ntx[w]++;
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(int w, logic val);
    if (w == 1) b1.rx = val;
    else b0.rx = val;
  endtask

  task automatic bit_time(int w, logic val);
    drive(w, val);
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send(int w, logic [7:0] b, bit bp, bit bstop);
    bit_time(w, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(w, b[i]);
    if (w == 1) bit_time(w, (^b) ^ bp);
    bit_time(w, !bstop);
    bit_time(w, 1'b1);
  endtask

  function automatic logic busy_of(int w);
    return (w == 1) ? b1.busy : b0.busy;
  endfunction

  task automatic settle(int w, string nm);
    int k;
    k = 0;
    repeat (5) @(negedge clk);
    while (busy_of(w) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout busy=1 exp=0", nm);
    end
    repeat (2 * DIV) @(negedge clk);
  endtask

  typedef struct {
    int v, f, h, d, tx, fb;
  } snap_t;

  function automatic snap_t take(int w);
    snap_t s;
    s.v = nv[w]; s.f = nf[w]; s.h = nh[w];
    s.d = nd[w]; s.tx = ntx[w]; s.fb = fbad[w];
    return s;
  endfunction

  task automatic check_resp(string nm, int w, int ei, snap_t s);
    int n, p;
    n = r_len(w);
    chk({nm, "_idx"}, hidx[w], ei);
    chk({nm, "_hitlat"}, hcyc[w] - vcyc[w], 1);
    chk({nm, "_txlat"}, txs[w][s.tx] - vcyc[w], 2);
    for (int j = 0; j < n; j++) begin
      p = s.tx + j;
      chk($sformatf("%s_b%0d", nm, j), txb[w][p],
          model_byte(w, ei, j));
      if (j > 0)
        chk($sformatf("%s_gap%0d", nm, j),
            txs[w][p] - txs[w][p-1], fw(w) * DIV);
    end
    chk({nm, "_busyend"}, bfall[w] - txs[w][s.tx+n-1],
        fw(w) * DIV);
  endtask

  task automatic expect_txn(string nm, int w, logic [7:0] b,
                            int ev, int ef, int ei, snap_t s);
    int hit;
    hit = (ei >= 0) ? 1 : 0;
    chk({nm, "_valid"}, nv[w] - s.v, ev);
    chk({nm, "_ferr"}, nf[w] - s.f, ef);
    if (ev != 0) chk({nm, "_byte"}, vb[w], int'(b));
    chk({nm, "_hit"}, nh[w] - s.h, hit);
    chk({nm, "_ntx"}, ntx[w] - s.tx, hit * r_len(w));
    chk({nm, "_frame"}, fbad[w] - s.fb, 0);
    if (hit == 1 && ntx[w] - s.tx == r_len(w))
      check_resp(nm, w, ei, s);
  endtask

  typedef struct {
    int w;
    logic [7:0] b;
    bit bp;
    bit bstop;
    int ev;
    int ef;
    int ei;
  } vec_t;

  vec_t vt[9];

  initial begin
    snap_t s;
    logic [7:0] rbyte;
    int w, k, ei;

    vt[0] = '{0, 8'h31, 0, 0, 1, 0, 0};
    vt[1] = '{0, 8'h32, 0, 0, 1, 0, 1};
    vt[2] = '{0, 8'h33, 0, 0, 1, 0, -1};
    vt[3] = '{1, 8'h41, 0, 0, 1, 0, 1};
    vt[4] = '{1, 8'h40, 0, 0, 1, 0, 0};
    vt[5] = '{1, 8'h31, 1, 0, 0, 1, -1};
    vt[6] = '{1, 8'h31, 0, 1, 0, 1, -1};
    vt[7] = '{0, 8'h55, 0, 1, 0, 1, -1};
    vt[8] = '{1, 8'h42, 0, 0, 1, 0, -1};

    b0.rx = 1'b1;
    b1.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx0", b0.tx, 1);
    chk("rst_busy0", b0.busy, 0);
    chk("rst_valid0", b0.rx_valid, 0);
    chk("rst_ferr0", b0.frame_err, 0);
    chk("rst_hit0", b0.cmd_hit, 0);
    chk("rst_drop0", b0.cmd_drop, 0);
    chk("rst_byte0", b0.rx_byte, 0);
    chk("rst_idx0", b0.cmd_idx, 0);
    chk("rst_tx1", b1.tx, 1);
    chk("rst_idx1", b1.cmd_idx, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      s = take(vt[i].w);
      send(vt[i].w, vt[i].b, vt[i].bp, vt[i].bstop);
      settle(vt[i].w, $sformatf("vec%0d", i));
      expect_txn($sformatf("vec%0d", i), vt[i].w, vt[i].b,
                 vt[i].ev, vt[i].ef, vt[i].ei, s);
    end

    // command arriving mid-response is dropped
    s = take(0);
    send(0, 8'h32, 0, 0);
    send(0, 8'h33, 0, 0);
    settle(0, "drop");
    chk("drop_valid", nv[0] - s.v, 2);
    chk("drop_hit", nh[0] - s.h, 1);
    chk("drop_pulse", nd[0] - s.d, 1);
    chk("drop_byte", vb[0], 8'h33);
    chk("drop_ntx", ntx[0] - s.tx, 4);
    if (ntx[0] - s.tx == 4) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("drop_b%0d", j), txb[0][s.tx+j],
            model_byte(0, 1, j));
    end

    // short low glitch is a false start
    s = take(0);
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    drive(0, 1'b1);
    repeat (4 * DIV) @(negedge clk);
    chk("glitch_valid", nv[0] - s.v, 0);
    chk("glitch_ferr", nf[0] - s.f, 0);
    s = take(0);
    send(0, 8'h31, 0, 0);
    settle(0, "post_glitch");
    expect_txn("post_glitch", 0, 8'h31, 1, 0, 0, s);

    // reset during the second response byte
    s = take(0);
    send(0, 8'h31, 0, 0);
    k = 0;
    while (ntx[0] < s.tx + 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    while (b0.tx !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      checks++;
      failures++;
      $display("FAIL rstmid_timeout tx=%0b exp=0", b0.tx);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_tx", b0.tx, 1);
    chk("rstmid_busy", b0.busy, 0);
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s = take(0);
    repeat (150) @(negedge clk);
    chk("lowrel_valid", nv[0] - s.v, 0);
    chk("lowrel_ferr", nf[0] - s.f, 0);
    chk("lowrel_tx", b0.tx, 1);
    chk("lowrel_busy", b0.busy, 0);
    chk("lowrel_ntx", ntx[0] - s.tx, 0);
    drive(0, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    s = take(0);
    send(0, 8'h32, 0, 0);
    settle(0, "post_rst");
    expect_txn("post_rst", 0, 8'h32, 1, 0, 1, s);

    // random bytes against the table model
    for (int i = 0; i < 20; i++) begin
      w = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        rbyte = code(w, int'($urandom_range(0, n_cmds(w) - 1)));
      else
        rbyte = 8'($urandom);
      ei = model_idx(w, rbyte);
      s = take(w);
      send(w, rbyte, 0, 0);
      settle(w, $sformatf("rnd%0d", i));
      expect_txn($sformatf("rnd%0d", i), w, rbyte, 1, 0, ei, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
